pop_position_ctrl: RTL
======================

// Module: pop_position_ctrl
// PURPOSE
//  Frame-synchronous controller feeding the two-frame popcat sprite stage.
//  - Debounces the pop button and samples the 16-bit LFSR on each press.
//  - Drives the sprite's centre position (x_com/y_com) and its open/closed select.
//  - Updates happen only on new_frame, so the sprite never tears mid-frame.
//  - Sits between video_sig_gen/lfsr_16 and image_sprite_2.
// PARAMETERS
//  DEBOUNCE_CYCLES  742500  consecutive stable samples required before a level change (10 ms @ 74.25 MHz)
//  OPEN_FRAMES      8       frames the mouth stays open per pop (>=1)
//  SCREEN_W         1280    active width in pixels
//  SCREEN_H         720     active height in pixels
//  SPRITE_W         256     displayed sprite width; SCREEN_W-SPRITE_W must lie in [513,1024]
//  SPRITE_H         256     displayed sprite height; SCREEN_H-SPRITE_H must lie in [257,512]
// PORTS
//  clk_pixel_in   in   1   pixel clock, sole clock
//  rst_in         in   1   reset, synchronous, active-low (0 = reset)
//  btn_in         in   1   raw asynchronous pop button, active-high
//  rand_in        in   16  LFSR output
//  nf_in          in   1   one-cycle new-frame pulse from video_sig_gen
//  x_com_out      out  11  sprite centre x
//  y_com_out      out  10  sprite centre y
//  open_out       out  1   1 = open-mouth sprite frame
//  busy_out       out  1   1 while a pop is pending or open
//  pop_count_out  out  16  pops shown (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_in==0 at a clock edge):
//    x_com_out=SCREEN_W/2, y_com_out=SCREEN_H/2, open_out=0, busy_out=0, pop_count_out=0.
//    Synchronizer, debounce counter and debounced level clear to 0. FSM returns to IDLE.
//    Reset mid-pop aborts the pop; no partial output is retained.
//  - Input path: btn_in -> 2-FF synchronizer -> debounce.
//    Debounced level flips once the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//    Any agreeing sample clears the counter.
//    pop_req is a 1-cycle pulse on the debounced 0->1 edge only.
//  - Position arithmetic, registered on the pop_req cycle:
//    xo = rand_in[15:6]; if xo >= XS then xo -= XS (XS = SCREEN_W-SPRITE_W).
//    yo = rand_in[8:0];  if yo >= YS then yo -= YS (YS = SCREEN_H-SPRITE_H).
//    Candidate position = (SPRITE_W/2 + xo, SPRITE_H/2 + yo).
//    Defaults give x in [128,1151], y in [128,591]; the sprite is always fully on screen.
//  - FSM states: IDLE, ARMED, OPEN.
//    IDLE: on pop_req, latch candidate -> ARMED.
//    ARMED: on the first nf_in strictly after the latch cycle, load x/y outputs, open_out=1, frame_cnt=0, pop_count+1 -> OPEN.
//    OPEN: on each nf_in, frame_cnt+1; at the nf_in where frame_cnt==OPEN_FRAMES-1, open_out=0 -> IDLE.
//    Result: open_out is high for exactly OPEN_FRAMES frame boundaries.
//  - Outputs change only on nf_in cycles (or reset). Position holds after close.
//  - busy_out = (state != IDLE). pop_req while busy is dropped; there is no queue.
//  - pop_req and nf_in in the same IDLE cycle: latch only; outputs load at the following nf_in.
//  - pop_count wraps 0xFFFF -> 0x0000.
// CONFIGURATION
//  POP_COUNTER_EN defined: pop_count_out is the registered 16-bit pop counter.
//  POP_COUNTER_EN undefined: counter logic is omitted and pop_count_out is tied to 16'h0000.
// STRUCTURE
//  - Package popcat_pkg: typedef enum logic [1:0] {IDLE, ARMED, OPEN} pop_state_t; localparams COM_XW=11, COM_YW=10.
//  - Sub-module pop_debounce (synchronizer + debounce + rising-edge pulse), parameter DEBOUNCE_CYCLES.
//  - Top module holds the FSM, fold arithmetic and counters.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, OPEN_FRAMES=3, nf_in every 50 cycles)
//  1. Hold rst_in=0 for 3 cycles -> x=640, y=360, open=0, busy=0, count=0.
//  2. rand_in=16'hFFFF, btn_in held high 10 cycles -> next nf_in: x=128+(1023-1024? no fold)=1151,
//     y=128+(511-464)=175, open=1. Exactly 3 nf_in later open=0. count=1.
//  3. btn_in glitch high for 3 cycles -> no pop_req, busy stays 0, outputs unchanged.
//  4. Second clean press while open=1 -> ignored: count stays 1, x/y unchanged, open timing unchanged.
//  5. Press with rand_in=16'h0000 landing on the same cycle as nf_in -> outputs unchanged that frame;
//     at the next nf_in x=128, y=128, open=1.
//  6. rst_in=0 for 1 cycle while in OPEN -> next cycle x=640, y=360, open=0, busy=0. With POP_COUNTER_EN, count=0.

Source files
------------

// File: rtl/popcat_pkg.sv
// popcat_pkg: shared state encoding and coordinate widths for the popcat sprite controller.
package popcat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    OPEN  = 2'd2
  } pop_state_t;

  localparam int COM_XW = 11;
  localparam int COM_YW = 10;

endpackage

// File: rtl/pop_debounce.sv
// pop_debounce: 2-FF synchronizer, counter-based debounce and a one-cycle pulse
// on each debounced rising edge of the pop button.
module pop_debounce #(
  parameter int DEBOUNCE_CYCLES = 742500
) (
  input  logic clk_pixel_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic pop_req_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples; pulse marks 0->1 flips.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Register synchronizer, debounce state and the edge pulse.
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pop_req_out = pulse_q;

endmodule

// File: rtl/pop_position_ctrl.sv
// pop_position_ctrl: frame-synchronous pop controller for the two-frame popcat sprite.
// Optional macro POP_COUNTER_EN: when defined, pop_count_out is a registered
// 16-bit pop counter; otherwise the counter is omitted and the port reads zero.
module pop_position_ctrl
  import popcat_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 742500,
  parameter int OPEN_FRAMES     = 8,
  parameter int SCREEN_W        = 1280,
  parameter int SCREEN_H        = 720,
  parameter int SPRITE_W        = 256,
  parameter int SPRITE_H        = 256
) (
  input  logic              clk_pixel_in,
  input  logic              rst_in,
  input  logic              btn_in,
  input  logic [15:0]       rand_in,
  input  logic              nf_in,
  output logic [COM_XW-1:0] x_com_out,
  output logic [COM_YW-1:0] y_com_out,
  output logic              open_out,
  output logic              busy_out,
  output logic [15:0]       pop_count_out
);

  localparam int FW = $clog2(OPEN_FRAMES + 1);
  localparam logic [FW-1:0]     FRAME_LAST = FW'(OPEN_FRAMES - 1);
  localparam logic [COM_XW-1:0] XS         = COM_XW'(SCREEN_W - SPRITE_W);
  localparam logic [COM_YW-1:0] YS         = COM_YW'(SCREEN_H - SPRITE_H);
  localparam logic [COM_XW-1:0] X_HALF     = COM_XW'(SPRITE_W / 2);
  localparam logic [COM_YW-1:0] Y_HALF     = COM_YW'(SPRITE_H / 2);
  localparam logic [COM_XW-1:0] X_RST      = COM_XW'(SCREEN_W / 2);
  localparam logic [COM_YW-1:0] Y_RST      = COM_YW'(SCREEN_H / 2);

  logic pop_req;

  pop_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_pixel_in(clk_pixel_in),
    .rst_in      (rst_in),
    .btn_in      (btn_in),
    .pop_req_out (pop_req)
  );

  pop_state_t        state_q, state_d;
  logic [COM_XW-1:0] x_q, x_d, cand_x_q, cand_x_d;
  logic [COM_YW-1:0] y_q, y_d, cand_y_q, cand_y_d;
  logic              open_q, open_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [COM_XW-1:0] xo;
  logic [COM_YW-1:0] yo;

  // Fold the random bits into the legal offset range and step through IDLE/ARMED/OPEN.
  always_comb begin
    xo = {1'b0, rand_in[15:6]};
    if (xo >= XS) xo = xo - XS;
    yo = {1'b0, rand_in[8:0]};
    if (yo >= YS) yo = yo - YS;

    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    open_d   = open_q;
    frame_d  = frame_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;

    case (state_q)
      IDLE: begin
        // A frame pulse on the latch cycle is deliberately ignored here.
        if (pop_req) begin
          cand_x_d = X_HALF + xo;
          cand_y_d = Y_HALF + yo;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (nf_in) begin
          x_d     = cand_x_q;
          y_d     = cand_y_q;
          open_d  = 1'b1;
          frame_d = '0;
          state_d = OPEN;
        end
      end
      OPEN: begin
        if (nf_in) begin
          if (frame_q == FRAME_LAST) begin
            open_d  = 1'b0;
            state_d = IDLE;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single register stage for FSM state and all registered outputs.
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      x_q      <= X_RST;
      y_q      <= Y_RST;
      open_q   <= 1'b0;
      frame_q  <= '0;
      cand_x_q <= X_RST;
      cand_y_q <= Y_RST;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      open_q   <= open_d;
      frame_q  <= frame_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
    end
  end

`ifdef POP_COUNTER_EN
  logic [15:0] count_q, count_d;

  // Count each pop as it becomes visible; wraps naturally at 16 bits.
  always_comb begin
    count_d = count_q;
    if ((state_q == ARMED) && nf_in) count_d = count_q + 16'd1;
  end

  // Pop counter register.
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) count_q <= '0;
    else         count_q <= count_d;
  end

  assign pop_count_out = count_q;
`else
  assign pop_count_out = 16'h0000;
`endif

  assign x_com_out = x_q;
  assign y_com_out = y_q;
  assign open_out  = open_q;
  assign busy_out  = (state_q != IDLE);

endmodule
